// File: rtl/branch_history_table.sv
// Per-PC (local) or single global branch history table: speculative shift at fetch,
// exact repair at resolve, combinational read ports with no write bypass.
module branch_history_table #(
    parameter int ENTRIES = 32,
    parameter int HIST_W  = 5,
    parameter int MODE    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(ENTRIES)-1:0] rd_index,
    output logic [HIST_W-1:0]          rd_hist,
    output logic                       rd_full,
    input  logic                       spec_en,
    input  logic [$clog2(ENTRIES)-1:0] spec_index,
    input  logic                       spec_taken,
    input  logic [$clog2(ENTRIES)-1:0] br_index,
    output logic [HIST_W-1:0]          br_hist,
    input  logic                       fix_en,
    input  logic [$clog2(ENTRIES)-1:0] fix_index,
    input  logic [HIST_W-1:0]          fix_hist,
    input  logic                       fix_taken
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int N     = (MODE == 1) ? 1 : ENTRIES;
    localparam int FW    = $clog2(HIST_W + 1);
    localparam logic [FW-1:0] FULL = FW'(HIST_W);

    logic [HIST_W-1:0] hist [N];
    logic [FW-1:0]     fill [N];

    // Global mode collapses every index onto the single register 0.
    logic [IDX_W-1:0] rd_i, br_i, spec_i, fix_i;
    assign rd_i   = (MODE == 1) ? '0 : rd_index;
    assign br_i   = (MODE == 1) ? '0 : br_index;
    assign spec_i = (MODE == 1) ? '0 : spec_index;
    assign fix_i  = (MODE == 1) ? '0 : fix_index;

    // Newest outcome enters at bit 0; the oldest bit falls off the top.
    function automatic logic [HIST_W-1:0] shift_in(input logic [HIST_W-1:0] h, input logic b);
        logic [HIST_W:0] w;
        w = {h, b};
        return w[HIST_W-1:0];
    endfunction

    logic [N-1:0] spec_hit, fix_hit;

    // Enables are tested first so X indices on an idle port cannot reach the state.
    always_comb begin
        spec_hit = '0;
        fix_hit  = '0;
        for (int i = 0; i < N; i++) begin
            fix_hit[i]  = fix_en && (fix_i == IDX_W'(i));
            spec_hit[i] = spec_en && (spec_i == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
                fill[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                // Repair wins a same-entry collision: the younger fetch is being flushed.
                if (fix_hit[i]) begin
                    hist[i] <= shift_in(fix_hist, fix_taken);
                    fill[i] <= FULL;
                end else if (spec_hit[i]) begin
                    hist[i] <= shift_in(hist[i], spec_taken);
                    fill[i] <= (fill[i] == FULL) ? FULL : fill[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_hist = '0;
        rd_full = 1'b0;
        br_hist = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_i == IDX_W'(i)) begin
                rd_hist = hist[i];
                rd_full = (fill[i] == FULL);
            end
            if (br_i == IDX_W'(i)) begin
                br_hist = hist[i];
            end
        end
    end
endmodule

// File: tb/tb_branch_history_table.sv
// Randomized and directed bench for branch_history_table: queue scoreboard against an
// arithmetic reference model, plus a global-mode instance.
module tb_branch_history_table;
    localparam int HW = 5;
    localparam int NE = 32;
    localparam int IW = 5;
    localparam int GW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [IW-1:0] rd_index = '0, spec_index = '0, br_index = '0, fix_index = '0;
    logic [HW-1:0] rd_hist, br_hist, fix_hist = '0;
    logic          rd_full, spec_en = 1'b0, spec_taken = 1'b0, fix_en = 1'b0, fix_taken = 1'b0;

    logic [IW-1:0] g_rd_index = '0, g_spec_index = '0, g_br_index = '0, g_fix_index = '0;
    logic [GW-1:0] g_rd_hist, g_br_hist, g_fix_hist = '0;
    logic          g_rd_full, g_spec_en = 1'b0, g_spec_taken = 1'b0, g_fix_en = 1'b0, g_fix_taken = 1'b0;

    branch_history_table #(.ENTRIES(NE), .HIST_W(HW), .MODE(0)) dut (
        .clk(clk), .rst(rst),
        .rd_index(rd_index), .rd_hist(rd_hist), .rd_full(rd_full),
        .spec_en(spec_en), .spec_index(spec_index), .spec_taken(spec_taken),
        .br_index(br_index), .br_hist(br_hist),
        .fix_en(fix_en), .fix_index(fix_index), .fix_hist(fix_hist), .fix_taken(fix_taken)
    );

    branch_history_table #(.ENTRIES(NE), .HIST_W(GW), .MODE(1)) gdut (
        .clk(clk), .rst(rst),
        .rd_index(g_rd_index), .rd_hist(g_rd_hist), .rd_full(g_rd_full),
        .spec_en(g_spec_en), .spec_index(g_spec_index), .spec_taken(g_spec_taken),
        .br_index(g_br_index), .br_hist(g_br_hist),
        .fix_en(g_fix_en), .fix_index(g_fix_index), .fix_hist(g_fix_hist), .fix_taken(g_fix_taken)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [2*HW:0] exp_q[$];   // {rd_full, rd_hist, br_hist}

    // Reference model: history as an integer, fill as an outcome count capped at HW.
    int unsigned hm[NE];
    int unsigned fm[NE];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            hm[i] = 0;
            fm[i] = 0;
        end
    endtask

    always begin : monitor
        logic [2*HW:0] e;
        @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("read_ports", {21'd0, rd_full, rd_hist, br_hist}, {21'd0, e});
        end
    end

    task automatic step(input logic se, input logic [IW-1:0] si, input logic st,
                        input logic fe, input logic [IW-1:0] fi, input logic [HW-1:0] fh,
                        input logic ft, input logic [IW-1:0] ri, input logic [IW-1:0] bi);
        @(negedge clk);
        spec_en = se; spec_index = se ? si : 'x; spec_taken = st;
        fix_en = fe; fix_index = fe ? fi : 'x; fix_hist = fh; fix_taken = ft;
        rd_index = ri; br_index = bi;
        // Reads are combinational from pre-edge contents.
        exp_q.push_back({(fm[ri] == HW), HW'(hm[ri]), HW'(hm[bi])});
        @(posedge clk);
        if (fe) begin
            hm[fi] = (fh * 2 + ft) % (1 << HW);
            fm[fi] = HW;
        end
        if (se && !(fe && fi == si)) begin
            hm[si] = (hm[si] * 2 + st) % (1 << HW);
            fm[si] = (fm[si] + 1 > HW) ? HW : fm[si] + 1;
        end
        #1;
        spec_en = 1'b0;
        fix_en = 1'b0;
        spec_index = '0;
        fix_index = '0;
    endtask

    task automatic peek(input logic [IW-1:0] ri, input logic [IW-1:0] bi);
        @(negedge clk);
        rd_index = ri;
        br_index = bi;
        #2;
    endtask

    initial begin
        logic [IW-1:0] si, fi;
        logic [IW-1:0] gi;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NE; i++) begin
            rd_index = IW'(i); br_index = IW'(i);
            #1;
            check("reset_rd_hist", {27'd0, rd_hist}, 32'd0);
            check("reset_rd_full", {31'd0, rd_full}, 32'd0);
        end

        // Six shifts into entry 7; full after the fifth.
        step(1, 7, 1, 0, 0, 0, 0, 7, 7);
        step(1, 7, 0, 0, 0, 0, 0, 7, 7);
        step(1, 7, 1, 0, 0, 0, 0, 7, 7);
        step(1, 7, 1, 0, 0, 0, 0, 7, 7);
        step(1, 7, 0, 0, 0, 0, 0, 7, 7);
        step(1, 7, 1, 0, 0, 0, 0, 7, 7);
        peek(7, 7);
        check("shift_hist", {27'd0, rd_hist}, 32'b01101);
        check("shift_full", {31'd0, rd_full}, 32'd1);

        // Repair of entry 2.
        step(0, 0, 0, 1, 2, 5'b01111, 1, 2, 2);
        step(0, 0, 0, 1, 2, 5'b00101, 0, 2, 2);
        peek(2, 2);
        check("repair_br_hist", {27'd0, br_hist}, 32'b01010);
        check("repair_full", {31'd0, rd_full}, 32'd1);

        // Collisions.
        step(1, 4, 1, 1, 4, 5'b00000, 0, 4, 4);
        peek(4, 4);
        check("collide_same", {27'd0, rd_hist}, 32'd0);
        step(1, 5, 1, 1, 4, 5'b00000, 0, 4, 5);
        peek(4, 5);
        check("collide_diff_fix", {27'd0, rd_hist}, 32'd0);
        check("collide_diff_spec", {31'd0, br_hist[0]}, 32'd1);

        // No bypass: the step's own expectation holds the pre-edge value.
        step(1, 1, 1, 0, 0, 0, 0, 1, 1);
        peek(1, 1);
        check("no_bypass_after", {31'd0, rd_hist[0]}, 32'd1);

        for (int n = 0; n < 400; n++) begin
            si = IW'($urandom_range(0, 7));
            fi = ($urandom_range(0, 1) == 1) ? si : IW'($urandom_range(0, NE - 1));
            step(1'($urandom_range(0, 1)), si, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), fi, HW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 IW'($urandom_range(0, NE - 1)), IW'($urandom_range(0, 7)));
        end

        // Asynchronous reset mid-cycle.
        step(0, 0, 0, 1, 3, 5'b01011, 0, 3, 3);
        @(negedge clk);
        rd_index = 3;
        #1;
        check("pre_reset_entry3", {27'd0, rd_hist}, 32'b10110);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_hist", {27'd0, rd_hist}, 32'd0);
        check("async_reset_full", {31'd0, rd_full}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NE; i++) begin
            rd_index = IW'(i); br_index = IW'(i);
            #1;
            check("post_reset_zero", {26'd0, rd_full, rd_hist}, 32'd0);
        end
        for (int n = 0; n < 100; n++) begin
            si = IW'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), si, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), IW'($urandom_range(0, 3)), HW'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), IW'($urandom_range(0, 3)), IW'($urandom_range(0, 3)));
        end

        // Global mode: every index aliases the single register.
        @(negedge clk);
        g_spec_en = 1; g_spec_index = 3; g_spec_taken = 1;
        @(posedge clk); #1;
        g_spec_index = 9;
        @(posedge clk); #1;
        g_spec_en = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            gi = IW'($urandom_range(0, NE - 1));
            g_rd_index = gi;
            g_br_index = IW'($urandom_range(0, NE - 1));
            #2;
            check("global_rd_hist", {24'd0, g_rd_hist}, 32'h03);
            check("global_br_hist", {24'd0, g_br_hist}, 32'h03);
            check("global_rd_full", {31'd0, g_rd_full}, 32'd0);
        end
        @(negedge clk);
        g_spec_en = 1; g_spec_index = 5; g_spec_taken = 1;
        g_fix_en = 1; g_fix_index = 12; g_fix_hist = 8'h81; g_fix_taken = 0;
        @(posedge clk); #1;
        g_spec_en = 0; g_fix_en = 0;
        @(negedge clk);
        g_rd_index = 20; g_br_index = 1;
        #2;
        check("global_collide_rd", {24'd0, g_rd_hist}, 32'h02);
        check("global_collide_br", {24'd0, g_br_hist}, 32'h02);
        check("global_collide_full", {31'd0, g_rd_full}, 32'd1);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_history_table.md
Name: branch_history_table

Overview:
Parametrised per-PC branch history table for the lc3b predictor front end.
- Holds ENTRIES shift registers of HIST_W outcome bits each, indexed by low PC bits.
- Supports a speculative shift at fetch with the predicted direction, and a repair write at resolve that replaces the entry with corrected history.
- MODE selects local, per-index tables or a single global history register.

Parameters:
ENTRIES, 32, number of history entries (power of two, >= 2); forced to 1 internally when MODE=1
HIST_W, 5, outcome bits kept per entry (1..16)
MODE, 0, 0 = local (per-index), 1 = global (single register, all index inputs ignored)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
rd_index  in  $clog2(ENTRIES)  fetch-stage lookup index
rd_hist  out  HIST_W  history at rd_index (combinational)
rd_full  out  1  entry at rd_index has recorded >= HIST_W outcomes
spec_en  in  1  speculative shift this cycle
spec_index  in  $clog2(ENTRIES)  entry to shift
spec_taken  in  1  predicted direction shifted in
br_index  in  $clog2(ENTRIES)  resolve-stage lookup index
br_hist  out  HIST_W  history at br_index (combinational)
fix_en  in  1  repair write this cycle
fix_index  in  $clog2(ENTRIES)  entry to repair
fix_hist  in  HIST_W  corrected history (pre-branch history at fetch)
fix_taken  in  1  actual resolved direction

Behaviour:
- Storage: ENTRIES x HIST_W history registers, plus ENTRIES x $clog2(HIST_W+1) saturating fill counters. Implemented in flops, not RAM.
- Reset (async, any time, including mid-update): every history entry and fill counter goes to 0 immediately. rd_hist = br_hist = 0 and rd_full = 0 while rst is high. Writes presented in the cycle rst deasserts take effect on the next rising edge.
- Speculative shift (spec_en=1, fix_en=0 or different index): entry[spec_index] <= {entry[HIST_W-2:0], spec_taken}. Newest outcome is in bit 0; the oldest bit is discarded. For HIST_W=1 the entry becomes spec_taken. The fill counter increments, saturating at HIST_W.
- Repair (fix_en=1): entry[fix_index] <= {fix_hist[HIST_W-2:0], fix_taken}. The fill counter is set to HIST_W. Repair is exact, never a shift of current contents.
- Same cycle, same index (after MODE mapping): repair wins and the speculative shift is dropped, because the younger fetch is being flushed. Different indices: both apply.
- Reads:
  - Purely combinational from current register contents, with no same-cycle write bypass.
  - A write at edge N is visible on rd_hist and br_hist from edge N onward.
  - rd_full = (fill[rd_index] == HIST_W).
- Latency: 0 cycles for reads, 1 edge for writes.
- MODE=1: all indices are treated as 0. The single register shifts on spec_en and repairs on fix_en with the same priority rule. rd_hist == br_hist at all times.
- Index inputs are always in range; no wrap handling is needed beyond natural width.
- No X propagation: when disabled, index inputs may be X without corrupting state.

Test Plan:
- Reset: write entry 3 to 5'b10110, assert rst asynchronously mid-cycle -> rd_hist=0 at rd_index=3 before the next edge; all 32 entries read 0 after reset; rd_full=0.
- Shift and saturate: from reset, 6 spec_en cycles on index 7 with taken=1,0,1,1,0,1 -> rd_hist=5'b01101 (oldest 1 dropped); rd_full goes 1 after the 5th shift and stays 1.
- Repair: entry 2 = 5'b11111, fix_en with fix_hist=5'b00101, fix_taken=0 -> br_hist[2]=5'b01010, rd_full=1.
- Collision: same cycle, spec_en idx 4 taken=1 and fix_en idx 4 with fix_hist=0, fix_taken=0 -> entry 4 = 0. Repeating with spec idx 5 -> entry 4 = 0 and entry 5 gains a 1 in bit 0.
- No bypass: spec_en idx 1 taken=1 with rd_index=1 -> rd_hist shows the old value that cycle and the new value after the edge.
- Global mode (MODE=1, HIST_W=8): spec on idx 3 then idx 9, taken=1,1 -> rd_hist=br_hist=8'h03 for any index.
